// File: rtl/barrel_rotate_arbiter.sv
// Two-requester round-robin arbiter that shares one rotate datapath.
// The result sits in a single output register with valid/ready backpressure.
module barrel_rotate_arbiter #(
   parameter int WIDTH = 4,
   parameter int SHW   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_din,
   input  logic [SHW-1:0]   req0_amt,
   input  logic             req0_dir,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_din,
   input  logic [SHW-1:0]   req1_amt,
   input  logic             req1_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_dout,
   output logic             out_id
);

   // Rotate through a doubled word: left keeps the upper half, right keeps the lower half.
   function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] din,
                                               input logic [SHW-1:0]   amt,
                                               input logic             dir);
      logic [2*WIDTH-1:0] dbl;
      logic [2*WIDTH-1:0] sh;
      dbl = {din, din};
      if (!dir) begin
         sh = dbl << amt;
         return sh[2*WIDTH-1:WIDTH];
      end
      sh = dbl >> amt;
      return sh[WIDTH-1:0];
   endfunction

   logic             last;
   logic             slot_free;
   logic             grant0;
   logic             grant1;
   logic             xfer0;
   logic             xfer1;
   logic [WIDTH-1:0] sel_din;
   logic [SHW-1:0]   sel_amt;
   logic             sel_dir;
   logic [WIDTH-1:0] rot_data;

   // On contention the requester not served last time wins.
   assign slot_free  = ~out_valid | out_ready;
   assign grant0     = req0_valid & (~req1_valid | last);
   assign grant1     = req1_valid & (~req0_valid | ~last);
   assign req0_ready = grant0 & slot_free;
   assign req1_ready = grant1 & slot_free;
   assign xfer0      = req0_valid & req0_ready;
   assign xfer1      = req1_valid & req1_ready;

   assign sel_din  = grant1 ? req1_din : req0_din;
   assign sel_amt  = grant1 ? req1_amt : req0_amt;
   assign sel_dir  = grant1 ? req1_dir : req0_dir;
   assign rot_data = rotate(sel_din, sel_amt, sel_dir);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_dout  <= '0;
         out_id    <= 1'b0;
         last      <= 1'b1;
      end else if (xfer0 | xfer1) begin
         out_valid <= 1'b1;
         out_dout  <= rot_data;
         out_id    <= xfer1;
         last      <= xfer1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_barrel_rotate_arbiter.sv
// Directed scoreboard bench for barrel_rotate_arbiter: expected results are queued
// by the stimulus, and a monitor pops and compares each accepted output.
module tb_barrel_rotate_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req0_dir;
   logic [3:0] req0_din;
   logic [1:0] req0_amt;
   logic       req1_valid, req1_ready, req1_dir;
   logic [3:0] req1_din;
   logic [1:0] req1_amt;
   logic       out_valid, out_ready, out_id;
   logic [3:0] out_dout;

   int errors = 0;
   int checks = 0;
   logic [4:0] exp_q[$];

   barrel_rotate_arbiter #(.WIDTH(4), .SHW(2)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din),
      .req0_amt(req0_amt), .req0_dir(req0_dir),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din),
      .req1_amt(req1_amt), .req1_dir(req1_dir),
      .out_valid(out_valid), .out_ready(out_ready), .out_dout(out_dout), .out_id(out_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic id, input logic [3:0] dout);
      exp_q.push_back({id, dout});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted output is compared against the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         logic [4:0] e;
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {out_id, out_dout}, 32'h0);
            checks++;
            errors++;
            $display("FAIL unexpected_output: got id=%0d dout=%b with empty queue", out_id, out_dout);
         end else begin
            e = exp_q.pop_front();
            chk("out_dout", out_dout, e[3:0]);
            chk("out_id", out_id, e[4]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      out_ready = 1'b1;
      req0_valid = 1'b0; req0_din = '0; req0_amt = '0; req0_dir = 1'b0;
      req1_valid = 1'b0; req1_din = '0; req1_amt = '0; req1_dir = 1'b0;
      idle(2);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_dout", out_dout, 0);
      chk("rst_out_id", out_id, 0);
      rst = 1'b0;

      // Left rotates from requester 0, back to back
      push(0, 4'b1011); push(0, 4'b0111); push(0, 4'b1110); push(0, 4'b1101);
      for (int a = 0; a < 4; a++) begin
         req0_valid = 1'b1; req0_din = 4'b1011; req0_amt = a[1:0]; req0_dir = 1'b0;
         @(negedge clk);
         chk("left_no_bubble_ready0", req0_ready, 1);
         @(posedge clk); #1;
      end
      req0_valid = 1'b0;

      // Right rotates from requester 1
      push(1, 4'b1011); push(1, 4'b1101); push(1, 4'b1110); push(1, 4'b0111);
      for (int a = 0; a < 4; a++) begin
         req1_valid = 1'b1; req1_din = 4'b1011; req1_amt = a[1:0]; req1_dir = 1'b1;
         @(negedge clk);
         chk("right_ready1", req1_ready, 1);
         @(posedge clk); #1;
      end
      req1_valid = 1'b0;
      idle(2);

      // Contention from reset: grants alternate starting with requester 0
      rst = 1'b1;
      req0_valid = 1'b1; req0_din = 4'b0001; req0_amt = 2'd1; req0_dir = 1'b0;
      req1_valid = 1'b1; req1_din = 4'b1000; req1_amt = 2'd1; req1_dir = 1'b1;
      idle(1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push(0, 4'b0010); push(1, 4'b0100);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("contend_ready0", req0_ready, (i % 2 == 0));
         chk("contend_ready1", req1_ready, (i % 2 == 1));
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      idle(2);

      // Backpressure: result held for 3 cycles, then drain and refill on one edge
      req0_valid = 1'b1; req1_valid = 1'b1;
      push(0, 4'b0010); push(1, 4'b0100);
      idle(1);
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_dout", out_dout, 4'b0010);
         chk("stall_id", out_id, 0);
         chk("stall_ready0", req0_ready, 0);
         chk("stall_ready1", req1_ready, 0);
         @(posedge clk);
      end
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("release_ready1", req1_ready, 1);
      chk("release_ready0", req0_ready, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      idle(2);

      // Reset mid-stream with a result held and both requesters valid
      req0_valid = 1'b1; req1_valid = 1'b1;
      idle(1);
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_dout", out_dout, 0);
      chk("midrst_out_id", out_id, 0);
      chk("midrst_ready0", req0_ready, 1);
      chk("midrst_ready1", req1_ready, 0);
      #3 rst = 1'b0;
      out_ready = 1'b1;
      push(0, 4'b0010); push(1, 4'b0100);
      idle(2);
      req0_valid = 1'b0; req1_valid = 1'b0;
      idle(2);

      // Idle drain: a single result, then nothing
      push(0, 4'b1100);
      req0_valid = 1'b1; req0_din = 4'b0110; req0_amt = 2'd1; req0_dir = 1'b0;
      idle(1);
      req0_valid = 1'b0;
      @(negedge clk);
      chk("drain_valid_hi", out_valid, 1);
      @(negedge clk);
      chk("drain_valid_lo", out_valid, 0);
      chk("drain_dout_kept", out_dout, 4'b1100);
      chk("drain_id_kept", out_id, 0);
      @(negedge clk);
      chk("drain_valid_lo2", out_valid, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
